// File: rtl/display_sequencer.sv
// Four-digit seven-segment display sequencer: loads up to four segment codes,
// rotates them on demand, and time-multiplexes them onto one digit at a time.
module display_sequencer #(
    parameter logic [7:0] BLANK_CODE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_rotate,
    input  logic       clear,
    input  logic       scan_tick,
    input  logic       step_tick,
    input  logic [7:0] code_in,
    output logic [7:0] pattern,
    output logic [3:0] SSD,
    output logic [1:0] state,
    output logic [2:0] load_position
);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_LOADING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_ROTATING = 2'd3;

    // All command inputs are single-cycle pulses sampled on the rising edge;
    // there is no back-pressure, so every pulse is acted on (or ignored) that cycle.
    logic [7:0] r_slot [4];
    logic [7:0] w_slot_nxt [4];
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_load_pos;
    logic [2:0] w_load_pos_nxt;
    logic [1:0] r_scan_idx;
    logic [1:0] w_scan_idx_nxt;
    logic [7:0] r_pattern;
    logic [3:0] r_ssd;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_pos_nxt = r_load_pos;
        for (int i = 0; i < 4; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end

        if (clear) begin
            for (int i = 0; i < 4; i++) begin
                w_slot_nxt[i] = BLANK_CODE;
            end
            w_load_pos_nxt = 3'd0;
            w_state_nxt    = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (load_rotate) begin
                        w_slot_nxt[0]  = code_in;
                        w_load_pos_nxt = 3'd1;
                        w_state_nxt    = ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (load_rotate) begin
                        w_slot_nxt[r_load_pos[1:0]] = code_in;
                        w_load_pos_nxt              = r_load_pos + 3'd1;
                        if (r_load_pos == 3'd3) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (load_rotate) begin
                        w_state_nxt = ST_ROTATING;
                    end
                end
                ST_ROTATING: begin
                    // Pause takes precedence over a coincident rotation step.
                    if (load_rotate) begin
                        w_state_nxt = ST_FULL;
                    end else if (step_tick) begin
                        w_slot_nxt[0] = r_slot[1];
                        w_slot_nxt[1] = r_slot[2];
                        w_slot_nxt[2] = r_slot[3];
                        w_slot_nxt[3] = r_slot[0];
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_scan_idx_nxt = scan_tick ? (r_scan_idx + 2'd1) : r_scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= BLANK_CODE;
            end
            r_state    <= ST_EMPTY;
            r_load_pos <= 3'd0;
            r_scan_idx <= 2'd0;
            r_pattern  <= BLANK_CODE;
            r_ssd      <= 4'b1110;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
            r_state    <= w_state_nxt;
            r_load_pos <= w_load_pos_nxt;
            r_scan_idx <= w_scan_idx_nxt;
            // Drive registers sample current index/slots, giving one cycle of latency.
            r_pattern  <= r_slot[r_scan_idx];
            r_ssd      <= ~(4'b0001 << r_scan_idx);
        end
    end

    assign pattern       = r_pattern;
    assign SSD           = r_ssd;
    assign state         = r_state;
    assign load_position = r_load_pos;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: loading, scanning, rotation, pause,
// clear priority, and asynchronous reset, with hand-computed expectations.
module tb_display_sequencer;

    logic       clk;
    logic       rst_n;
    logic       load_rotate;
    logic       clear;
    logic       scan_tick;
    logic       step_tick;
    logic [7:0] code_in;
    logic [7:0] pattern;
    logic [3:0] SSD;
    logic [1:0] state;
    logic [2:0] load_position;

    int         n_checks;
    int         n_fail;
    logic [1:0] tb_idx;
    logic [7:0] exp_q[$];

    display_sequencer #(.BLANK_CODE(8'hFF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_rotate   (load_rotate),
        .clear         (clear),
        .scan_tick     (scan_tick),
        .step_tick     (step_tick),
        .code_in       (code_in),
        .pattern       (pattern),
        .SSD           (SSD),
        .state         (state),
        .load_position (load_position)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Driver: called at a negedge, applies inputs for one rising edge, returns at next negedge.
    task automatic drive(input logic lr, input logic clr, input logic st, input logic sc,
                         input logic [7:0] code);
        load_rotate = lr;
        clear       = clr;
        step_tick   = st;
        scan_tick   = sc;
        code_in     = code;
        @(negedge clk);
        load_rotate = 1'b0;
        clear       = 1'b0;
        step_tick   = 1'b0;
        scan_tick   = 1'b0;
        code_in     = 8'h00;
        if (sc) tb_idx = tb_idx + 2'd1;
    endtask

    task automatic scan_step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic check_disp(input string tag, input logic [7:0] exp_pat);
        logic [3:0] exp_ssd;
        exp_ssd = ~(4'b0001 << tb_idx);
        check_eq({tag, "_pat"}, {24'd0, pattern}, {24'd0, exp_pat});
        check_eq({tag, "_ssd"}, {28'd0, SSD}, {28'd0, exp_ssd});
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        tb_idx      = 2'd0;
        rst_n       = 1'b0;
        load_rotate = 1'b0;
        clear       = 1'b0;
        scan_tick   = 1'b0;
        step_tick   = 1'b0;
        code_in     = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_in_state", {30'd0, state}, 32'd0);
        check_eq("rst_in_ssd", {28'd0, SSD}, 32'hE);
        check_eq("rst_in_pat", {24'd0, pattern}, 32'hFF);
        rst_n = 1'b1;

        // Idle after reset: values hold
        repeat (5) @(negedge clk);
        check_eq("idle_state", {30'd0, state}, 32'd0);
        check_eq("idle_lpos", {29'd0, load_position}, 32'd0);
        check_eq("idle_ssd", {28'd0, SSD}, 32'hE);
        check_eq("idle_pat", {24'd0, pattern}, 32'hFF);

        // Load four digits; step_tick while LOADING is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hC0);
        check_eq("load1_state", {30'd0, state}, 32'd1);
        check_eq("load1_lpos", {29'd0, load_position}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hF9);
        check_eq("load2_lpos", {29'd0, load_position}, 32'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("loadstep_state", {30'd0, state}, 32'd1);
        check_eq("loadstep_lpos", {29'd0, load_position}, 32'd2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA4);
        check_eq("load3_lpos", {29'd0, load_position}, 32'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hB0);
        check_eq("full_state", {30'd0, state}, 32'd2);
        check_eq("full_lpos", {29'd0, load_position}, 32'd4);

        // Scoreboard scan of the loaded digits
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hF9);
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'hB0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) scan_step();
            settle();
            check_disp("scan_full", exp_q.pop_front());
        end
        scan_step();
        settle();
        check_disp("scan_wrap", 8'hC0);

        // Start rotating, two steps
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("rot_state", {30'd0, state}, 32'd3);
        check_eq("rot_lpos", {29'd0, load_position}, 32'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("rot2_state", {30'd0, state}, 32'd3);
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hF9);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) scan_step();
            settle();
            check_disp("scan_rot", exp_q.pop_front());
        end
        scan_step();

        // Pause: FULL, slots frozen under step_tick
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("pause_state", {30'd0, state}, 32'd2);
        check_eq("pause_lpos", {29'd0, load_position}, 32'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        check_disp("frozen", 8'hA4);

        // Coincident pause and step: pause wins
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("rot_again", {30'd0, state}, 32'd3);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("coinc_state", {30'd0, state}, 32'd2);
        settle();
        check_disp("coinc_norot", 8'hA4);

        // Mid-rotation asynchronous reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        check_disp("rot_one", 8'hB0);
        scan_step();
        settle();
        check_disp("rot_one_s1", 8'hC0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", {30'd0, state}, 32'd0);
        check_eq("arst_lpos", {29'd0, load_position}, 32'd0);
        check_eq("arst_ssd", {28'd0, SSD}, 32'hE);
        check_eq("arst_pat", {24'd0, pattern}, 32'hFF);
        @(negedge clk);
        rst_n  = 1'b1;
        tb_idx = 2'd0;
        settle();
        check_eq("post_arst_state", {30'd0, state}, 32'd0);
        check_disp("post_arst", 8'hFF);

        // Slot write coincident with scan_tick; then clear beats load_rotate
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
        check_eq("two_lpos", {29'd0, load_position}, 32'd2);
        check_eq("two_state", {30'd0, state}, 32'd1);
        settle();
        check_disp("write_scan", 8'h22);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
        check_eq("clr_state", {30'd0, state}, 32'd0);
        check_eq("clr_lpos", {29'd0, load_position}, 32'd0);
        settle();
        check_disp("clr_scan2", 8'hFF);
        for (int k = 0; k < 3; k++) begin
            scan_step();
            settle();
            check_disp("clr_slots", 8'hFF);
        end

        // Resume loading from EMPTY
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        check_eq("resume_state", {30'd0, state}, 32'd1);
        check_eq("resume_lpos", {29'd0, load_position}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter BLANK_CODE, default 8'hFF; segment code for an empty digit slot, all segments off, active-low.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load_rotate  input  1  single-cycle command pulse (already one-pulsed upstream).
REQ-005 clear  input  1  single-cycle pulse; empties the display buffer.
REQ-006 scan_tick  input  1  single-cycle enable; advances the digit scan.
REQ-007 step_tick  input  1  single-cycle enable; advances rotation.
REQ-008 code_in  input  8  decoded segment code to load.
REQ-009 pattern  output  8  segment drive for the currently scanned digit, registered.
REQ-010 SSD  output  4  one-hot active-low digit enable, registered.
REQ-011 state  output  2  current FSM state encoding.
REQ-012 load_position  output  3  number of slots loaded, 0..4.

Function
REQ-013 Four 8-bit digit slots, slot0..slot3, shall hold the display buffer.
REQ-014 FSM states shall be EMPTY=2'd0, LOADING=2'd1, FULL=2'd2 and ROTATING=2'd3.
REQ-015 EMPTY + load_rotate shall write code_in to slot0, set load_position=1 and go to LOADING.
REQ-016 LOADING + load_rotate shall write code_in to slot[load_position] and increment load_position.
REQ-017 The write to slot3 shall set load_position=4 and go to FULL.
REQ-018 FULL + load_rotate shall go to ROTATING, with no slot write.
REQ-019 ROTATING + step_tick shall rotate the slots left: slot0<=slot1, slot1<=slot2, slot2<=slot3, slot3<=slot0.
REQ-020 ROTATING + load_rotate shall go to FULL (pause) with slots unchanged.
REQ-021 If load_rotate and step_tick coincide in ROTATING, the pause shall win and no rotation shall occur that cycle.
REQ-022 step_tick shall be ignored in every state other than ROTATING.
REQ-023 clear shall, from any state, set all slots to BLANK_CODE, load_position=0 and state=EMPTY on the next edge.
REQ-024 clear shall have priority over load_rotate and step_tick in the same cycle.
REQ-025 A 2-bit scan index shall increment on scan_tick and wrap from 3 to 0.
REQ-026 Scan shall run in all states and be unaffected by clear.
REQ-027 Each cycle, SSD shall be registered as ~(4'b0001 << idx) and pattern as slot[idx].
REQ-028 SSD and pattern shall therefore show a 1-cycle latency from any change in scan index or slot contents.
REQ-029 A slot write and a scan_tick in the same cycle shall both take effect.
REQ-030 load_rotate shall never change load_position while state is FULL or ROTATING.

Reset
REQ-031 rst_n low shall asynchronously set slots=BLANK_CODE, state=EMPTY, load_position=0, scan idx=0, pattern=BLANK_CODE and SSD=4'b1110.
REQ-032 Reset asserted mid-load or mid-rotation shall discard all buffer contents; after release, operation shall resume from EMPTY.

Verification
REQ-033 Reset then release, no inputs -> state=0, load_position=0, SSD=4'b1110, pattern=8'hFF held indefinitely.
REQ-034 Four load_rotate pulses with code_in 8'hC0, 8'hF9, 8'hA4, 8'hB0 -> state=2 and load_position=4; scanning idx0..3 gives pattern C0, F9, A4, B0 with SSD 1110, 1101, 1011, 0111.
REQ-035 From FULL (REQ-034), pulse load_rotate, then two step_ticks -> state=3; slots become A4, B0, C0, F9; a further load_rotate gives state=2 and slots stay frozen under more step_ticks.
REQ-036 In ROTATING, load_rotate and step_tick in the same cycle -> state=2, no rotation.
REQ-037 After two loads (load_position=2), clear and load_rotate pulsed together -> state=0, load_position=0, all slots 8'hFF.
REQ-038 rst_n pulsed low mid-rotation, asynchronously between edges -> outputs take reset values immediately without waiting for clk.
